// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM state type for the text console write controller.
package text_console_pkg;
  localparam int COLS   = 70;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, ROW_CLR} state_t;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction
endpackage

// File: rtl/console_cursor.sv
// Cursor position plus the row_base register (row*COLS), stepped by +/-COLS so no multiplier is needed.
module console_cursor #(
  parameter int COLS   = 70,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              advance,
  input  logic              newline,
  input  logic              cr,
  input  logic              back,
  input  logic              home,
  output logic [6:0]        col,
  output logic [4:0]        row,
  output logic [ADDR_W-1:0] row_base,
  output logic              wrap,
  output logic              nl_wrap,
  output logic              at_origin
);
  localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(COLS);

  assign nl_wrap   = (row == ROW_LAST);
  assign wrap      = (col == COL_LAST) && nl_wrap;
  assign at_origin = (col == 7'd0) && (row == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (newline || (advance && col == COL_LAST)) begin
      col <= '0;
      if (nl_wrap) begin
        row      <= '0;
        row_base <= '0;
      end else begin
        row      <= row + 5'd1;
        row_base <= row_base + STEP;
      end
    end else if (advance) begin
      col <= col + 7'd1;
    end else if (cr) begin
      col <= '0;
    end else if (back && !at_origin) begin
      if (col != 7'd0) begin
        col <= col - 7'd1;
      end else begin
        col      <= COL_LAST;
        row      <= row - 5'd1;
        row_base <= row_base - STEP;
      end
    end
  end
endmodule

// File: rtl/text_console_ctrl.sv
// Write-side controller for the VGA text RAM: character stream in, one RAM cell write per cycle out.
module text_console_ctrl #(
  parameter int         COLS       = text_console_pkg::COLS,
  parameter int         ROWS       = text_console_pkg::ROWS,
  parameter logic [7:0] BLANK_CODE = 8'd33,
  parameter bit         INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);
  import text_console_pkg::*;

  localparam logic [ADDR_W-1:0] CELL_LAST    = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_CLR_LAST = ADDR_W'(COLS - 1);

  state_t             state, state_nx, clr_state;
  logic [ADDR_W-1:0]  cnt, cnt_nx, row_base, cur_addr, addr_nx;
  logic [7:0]         data_nx;
  logic               wren_nx, wr_adv, wr_adv_nx, clr_wr, go_clr, xfer;
  logic               adv, nl, crc, bk, hm, wrap, nl_wrap, at_origin;

  console_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk(clk), .rst_n(rst_n),
    .advance(adv), .newline(nl), .cr(crc), .back(bk), .home(hm),
    .col(cursor_col), .row(cursor_row), .row_base(row_base),
    .wrap(wrap), .nl_wrap(nl_wrap), .at_origin(at_origin)
  );

  assign xfer     = in_valid && in_ready;
  assign cur_addr = row_base + ADDR_W'(cursor_col);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_adv_nx = wr_adv;
    wren_nx   = 1'b0;
    addr_nx   = ram_addr;
    data_nx   = ram_data;
    clr_wr    = 1'b0;
    go_clr    = 1'b0;
    clr_state = CLEAR;
    adv = 1'b0; nl = 1'b0; crc = 1'b0; bk = 1'b0; hm = 1'b0;
    case (state)
      IDLE: if (xfer) begin
        if (is_print(in_char)) begin
          wren_nx   = 1'b1;
          addr_nx   = cur_addr;
          data_nx   = in_char + 8'd1;
          wr_adv_nx = 1'b1;
          state_nx  = WRITE;
        end else begin
          case (in_char)
            LF: begin
              nl = 1'b1;
              if (nl_wrap) begin
                go_clr    = 1'b1;
                clr_state = ROW_CLR;
              end
            end
            CR: crc = 1'b1;
            BS: if (!at_origin) begin
              // the cell just before the cursor is always cur_addr-1, even across a row boundary
              bk        = 1'b1;
              wren_nx   = 1'b1;
              addr_nx   = cur_addr - 12'd1;
              data_nx   = BLANK_CODE;
              wr_adv_nx = 1'b0;
              state_nx  = WRITE;
            end
            FF: begin
              hm     = 1'b1;
              go_clr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_nx = IDLE;
        if (wr_adv) begin
          adv = 1'b1;
          if (wrap) begin
            go_clr    = 1'b1;
            clr_state = ROW_CLR;
          end
        end
      end
      CLEAR, ROW_CLR: begin
        wren_nx = 1'b1;
        addr_nx = cnt;
        data_nx = BLANK_CODE;
        clr_wr  = 1'b1;
        cnt_nx  = cnt + 12'd1;
        if (cnt == ((state == CLEAR) ? CELL_LAST : ROW_CLR_LAST)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Row clear only ever follows a bottom wrap, so it always covers row 0 (addr 0..COLS-1).
    // The first blank is issued on the entry edge so the write burst has no bubble.
    if (go_clr) begin
      wren_nx  = 1'b1;
      addr_nx  = '0;
      data_nx  = BLANK_CODE;
      clr_wr   = 1'b1;
      cnt_nx   = 12'd1;
      state_nx = clr_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLEAR) state <= CLEAR;
      else            state <= IDLE;
      cnt      <= '0;
      wr_adv   <= 1'b0;
      ram_wren <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      in_ready <= 1'b0;
      busy     <= INIT_CLEAR;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      wr_adv   <= wr_adv_nx;
      ram_wren <= wren_nx;
      ram_addr <= addr_nx;
      ram_data <= data_nx;
      // busy tracks the visible blank writes; accept again only once the last one has retired
      busy     <= clr_wr;
      in_ready <= (state_nx == IDLE) && !clr_wr;
    end
  end
endmodule

// File: tb/tb_text_console_ctrl.sv
// Randomized and directed bench for text_console_ctrl against a queue-of-writes screen model.
module tb_text_console_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready, ram_wren, busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  text_console_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [19:0] exp_q[$];
  int m_col = 0, m_row = 0;
  int wr_cnt = 0, busy_cyc = 0, w0;
  logic [11:0] last_addr = '0, a0;
  logic [7:0]  last_data = '0, c;
  logic [19:0] e;
  int r;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---- screen model: cursor plus the ordered list of cell writes it must cause ----
  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({12'(i), 8'd33});
  endtask

  task automatic m_newline();
    m_col = 0;
    if (m_row == 29) begin
      m_row = 0;
      push_run(70);
    end else m_row++;
  endtask

  task automatic model(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back({12'(m_row * 70 + m_col), 8'(ch + 8'd1)});
      if (m_col < 69) m_col++;
      else m_newline();
    end else if (ch == 8'h0A) m_newline();
    else if (ch == 8'h0D) m_col = 0;
    else if (ch == 8'h08) begin
      if (m_col != 0 || m_row != 0) begin
        if (m_col > 0) m_col--;
        else begin m_col = 69; m_row--; end
        exp_q.push_back({12'(m_row * 70 + m_col), 8'd33});
      end
    end else if (ch == 8'h0C) begin
      m_col = 0; m_row = 0;
      push_run(2100);
    end
  endtask

  // ---- per-cycle compare ----
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) chk("wren_in_reset", ram_wren, 0);
    else begin
      if (busy) busy_cyc++;
      if (ram_wren) begin
        wr_cnt++; last_addr = ram_addr; last_data = ram_data;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", ram_addr, ram_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", ram_addr, e[19:8]);
          chk("wr_data", ram_data, e[7:0]);
        end
      end
      if (in_ready) begin
        chk("ready_with_pending_writes", exp_q.size(), 0);
        chk("cursor_col", cursor_col, m_col);
        chk("cursor_row", cursor_row, m_row);
      end
    end
  end

  task automatic send(input logic [7:0] ch);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_char = ch; n = 0;
    while (!in_ready && n < 5000) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 5000 cycles");
      in_valid = 1'b0;
      return;
    end
    model(ch);
    @(posedge clk); #1;
    in_valid = 1'b0; in_char = 8'($urandom);
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!(in_ready && exp_q.size() == 0) && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL settle_timeout: got pending=%0d expected 0", exp_q.size());
    end
  endtask

  function automatic logic [7:0] rand_print();
    return 8'($urandom_range(32, 126));
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // 1. power-up clear
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1);
    chk("reset_ready", in_ready, 0);
    chk("reset_addr", ram_addr, 0);
    push_run(2100);
    rst_n = 1'b1;
    settle();
    chk("init_clear_count", wr_cnt, 2100);
    chk("init_clear_last_addr", last_addr, 2099);
    chk("init_clear_data", last_data, 33);
    chk("init_busy_low", busy, 0);
    chk("init_ready", in_ready, 1);

    // 2. 'A' at origin
    w0 = wr_cnt;
    send(8'h41); settle();
    chk("A_writes", wr_cnt - w0, 1);
    chk("A_addr", last_addr, 0);
    chk("A_data", last_data, 8'h42);
    chk("A_col", cursor_col, 1);

    // 3. 'Z' at (69,2)
    send(8'h0D); send(8'h0A); send(8'h0A);
    repeat (69) send(rand_print());
    settle();
    chk("pos3_col", cursor_col, 69);
    chk("pos3_row", cursor_row, 2);
    send(8'h5A); settle();
    chk("Z_addr", last_addr, 209);
    chk("Z_data", last_data, 8'h5B);
    chk("Z_col", cursor_col, 0);
    chk("Z_row", cursor_row, 3);

    // 4. bottom-right wrap with row clear
    send(8'h0D);
    repeat (26) send(8'h0A);
    repeat (69) send(rand_print());
    settle();
    chk("pos4_row", cursor_row, 29);
    w0 = wr_cnt; busy_cyc = 0;
    send(8'h78); settle();
    chk("wrap_writes", wr_cnt - w0, 71);
    chk("wrap_busy_cycles", busy_cyc, 70);
    chk("wrap_last_addr", last_addr, 69);
    chk("wrap_col", cursor_col, 0);
    chk("wrap_row", cursor_row, 0);

    // 5. backspace across row start, then at origin
    send(8'h0A); send(8'h08); settle();
    chk("bs_col", cursor_col, 69);
    chk("bs_row", cursor_row, 0);
    chk("bs_addr", last_addr, 69);
    chk("bs_data", last_data, 33);
    repeat (69) send(8'h08);
    settle();
    w0 = wr_cnt;
    send(8'h08); repeat (3) @(negedge clk);
    chk("bs_origin_writes", wr_cnt - w0, 0);
    chk("bs_origin_col", cursor_col, 0);

    // idle with in_valid low: nothing moves
    a0 = ram_addr; w0 = wr_cnt;
    repeat (50) @(negedge clk);
    chk("idle_writes", wr_cnt - w0, 0);
    chk("idle_addr", ram_addr, a0);

    // 6. FF queued behind a WRITE, then reset mid-CLEAR
    send(8'h71); send(8'h0C);
    repeat (500) @(negedge clk);
    chk("clear_wren_active", ram_wren, 1);
    rst_n = 1'b0; #1;
    chk("rst_wren_drop", ram_wren, 0);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    chk("rst_busy", busy, 1);
    exp_q.delete(); m_col = 0; m_row = 0;
    repeat (2) @(negedge clk);
    push_run(2100);
    rst_n = 1'b1;
    settle();
    chk("reclear_last_addr", last_addr, 2099);

    // random stream
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 999);
      if (r < 3) c = 8'h0C;
      else if (r < 103) c = 8'h0A;
      else if (r < 130) c = 8'h0D;
      else if (r < 180) c = 8'h08;
      else if (r < 220) begin
        c = 8'($urandom_range(0, 255));
        while ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C)
          c = 8'($urandom_range(0, 255));
      end else c = rand_print();
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      send(c);
    end
    settle();
    chk("final_col", cursor_col, m_col);
    chk("final_row", cursor_row, m_row);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
